// File: rtl/pkt_proc_pkg.sv
// Shared definitions for the AXI-Lite memory responder: response codes and
// the transaction FSM state encoding.
package pkt_proc_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_MEM  = 3'd1,
      WR_RESP = 3'd2,
      RD_MEM  = 3'd3,
      RD_WAIT = 3'd4,
      RD_RESP = 3'd5
   } axil_mem_state_t;

endpackage

// File: rtl/axil_hold_reg.sv
// One-entry valid/ready holding register. Accepts a beat whenever empty and
// keeps it until the consumer pulses clr. Ready is forced low during reset.
module axil_hold_reg #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              clr,
   output logic              held,
   output logic [DATA_W-1:0] data
);

   assign in_ready = rst_n & ~held;

   // Capture on handshake; release when the FSM consumes the entry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         held <= 1'b0;
         data <= '0;
      end else if (in_valid && in_ready) begin
         held <= 1'b1;
         data <= in_data;
      end else if (clr) begin
         held <= 1'b0;
      end
   end

endmodule

// File: rtl/axil_mem_resp.sv
// AXI4-Lite slave terminating one memory window onto a single-port
// synchronous SRAM. AW, W and AR are buffered independently; a single FSM
// serialises transactions, alternating between reads and writes when both
// are pending. All SRAM port signals are registered.
module axil_mem_resp
   import pkt_proc_pkg::*;
#(
   parameter int          ADDR_W     = 16,
   parameter int unsigned MEM_BYTES  = 65536,
   parameter int          RD_LATENCY = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] s_axil_awaddr,
   input  logic              s_axil_awvalid,
   output logic              s_axil_awready,
   input  logic [31:0]       s_axil_wdata,
   input  logic [3:0]        s_axil_wstrb,
   input  logic              s_axil_wvalid,
   output logic              s_axil_wready,
   output logic [1:0]        s_axil_bresp,
   output logic              s_axil_bvalid,
   input  logic              s_axil_bready,
   input  logic [ADDR_W-1:0] s_axil_araddr,
   input  logic              s_axil_arvalid,
   output logic              s_axil_arready,
   output logic [31:0]       s_axil_rdata,
   output logic [1:0]        s_axil_rresp,
   output logic              s_axil_rvalid,
   input  logic              s_axil_rready,
   output logic              mem_en,
   output logic [3:0]        mem_we,
   output logic [ADDR_W-3:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   localparam logic [1:0] RD_CNT_INIT = 2'(RD_LATENCY - 1);

   // Out-of-range test at full address width, widened so MEM_BYTES never truncates
   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      logic [32:0] wide;
      wide = '0;
      wide[ADDR_W-1:0] = a;
      return wide < {1'b0, MEM_BYTES};
   endfunction

   axil_mem_state_t state_q, state_d;

   logic              aw_held, w_held, ar_held;
   logic [ADDR_W-1:0] aw_addr_q, ar_addr_q;
   logic [35:0]       w_bus_q;
   logic [31:0]       w_data_q;
   logic [3:0]        w_strb_q;
   logic              clr_aw, clr_w, clr_ar;
   logic              grant_wr, grant_rd;
   logic              prefer_rd;
   logic              rd_err;
   logic [1:0]        rd_cnt;
   logic              aw_ok, ar_ok;

   assign w_data_q = w_bus_q[31:0];
   assign w_strb_q = w_bus_q[35:32];
   assign aw_ok    = in_range(aw_addr_q);
   assign ar_ok    = in_range(ar_addr_q);

   axil_hold_reg #(.DATA_W(ADDR_W)) u_aw_hold (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_data  (s_axil_awaddr),
      .in_valid (s_axil_awvalid),
      .in_ready (s_axil_awready),
      .clr      (clr_aw),
      .held     (aw_held),
      .data     (aw_addr_q)
   );

   axil_hold_reg #(.DATA_W(36)) u_w_hold (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_data  ({s_axil_wstrb, s_axil_wdata}),
      .in_valid (s_axil_wvalid),
      .in_ready (s_axil_wready),
      .clr      (clr_w),
      .held     (w_held),
      .data     (w_bus_q)
   );

   axil_hold_reg #(.DATA_W(ADDR_W)) u_ar_hold (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_data  (s_axil_araddr),
      .in_valid (s_axil_arvalid),
      .in_ready (s_axil_arready),
      .clr      (clr_ar),
      .held     (ar_held),
      .data     (ar_addr_q)
   );

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state, arbitration and holding-register release
   always_comb begin
      state_d  = state_q;
      grant_wr = 1'b0;
      grant_rd = 1'b0;
      clr_aw   = 1'b0;
      clr_w    = 1'b0;
      clr_ar   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (aw_held && w_held && (!ar_held || !prefer_rd)) begin
               grant_wr = 1'b1;
               state_d  = WR_MEM;
            end else if (ar_held) begin
               grant_rd = 1'b1;
               state_d  = RD_MEM;
            end
         end
         WR_MEM: begin
            clr_aw  = 1'b1;
            clr_w   = 1'b1;
            state_d = WR_RESP;
         end
         WR_RESP: begin
            if (s_axil_bready) state_d = IDLE;
         end
         RD_MEM: begin
            clr_ar  = 1'b1;
            state_d = RD_WAIT;
         end
         RD_WAIT: begin
            if (rd_cnt == 2'd0) state_d = RD_RESP;
         end
         RD_RESP: begin
            if (s_axil_rready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // SRAM port registers, loaded at grant so the access is live in WR_MEM/RD_MEM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_en    <= 1'b0;
         mem_we    <= 4'h0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else if (grant_wr) begin
         mem_en    <= aw_ok;
         mem_we    <= aw_ok ? w_strb_q : 4'h0;
         mem_addr  <= aw_addr_q[ADDR_W-1:2];
         mem_wdata <= w_data_q;
      end else if (grant_rd) begin
         mem_en    <= ar_ok;
         mem_we    <= 4'h0;
         mem_addr  <= ar_addr_q[ADDR_W-1:2];
      end else begin
         mem_en    <= 1'b0;
         mem_we    <= 4'h0;
      end
   end

   // Response channels, read-latency counter and fairness flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_axil_bvalid <= 1'b0;
         s_axil_bresp  <= RESP_OKAY;
         s_axil_rvalid <= 1'b0;
         s_axil_rdata  <= '0;
         s_axil_rresp  <= RESP_OKAY;
         rd_cnt        <= 2'd0;
         rd_err        <= 1'b0;
         prefer_rd     <= 1'b0;
      end else begin
         if (grant_wr)      prefer_rd <= 1'b1;
         else if (grant_rd) prefer_rd <= 1'b0;
         unique case (state_q)
            WR_MEM: begin
               s_axil_bvalid <= 1'b1;
               s_axil_bresp  <= aw_ok ? RESP_OKAY : RESP_SLVERR;
            end
            WR_RESP: begin
               if (s_axil_bready) begin
                  s_axil_bvalid <= 1'b0;
                  s_axil_bresp  <= RESP_OKAY;
               end
            end
            RD_MEM: begin
               rd_err <= ~ar_ok;
               rd_cnt <= RD_CNT_INIT;
            end
            RD_WAIT: begin
               if (rd_cnt != 2'd0) begin
                  rd_cnt <= rd_cnt - 2'd1;
               end else begin
                  s_axil_rvalid <= 1'b1;
                  s_axil_rdata  <= rd_err ? 32'h0 : mem_rdata;
                  s_axil_rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
               end
            end
            RD_RESP: begin
               if (s_axil_rready) s_axil_rvalid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_axil_mem_resp.sv
// Directed bench for axil_mem_resp (ADDR_W=17, MEM_BYTES=64KiB, RD_LATENCY=2)
// with a behavioural byte-writable SRAM and a log of every SRAM access.
module tb_axil_mem_resp;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [16:0] awaddr = '0;
   logic        awvalid = 1'b0;
   logic        awready;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        wvalid = 1'b0;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready = 1'b0;
   logic [16:0] araddr = '0;
   logic        arvalid = 1'b0;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready = 1'b0;
   logic        mem_en;
   logic [3:0]  mem_we;
   logic [14:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   int n_vec = 0;
   int n_bad = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   axil_mem_resp #(.ADDR_W(17), .MEM_BYTES(65536), .RD_LATENCY(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
      .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
      .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
      .s_axil_araddr(araddr), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
      .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   // Behavioural SRAM, two-cycle read latency
   logic [31:0] sram [0:32767];
   logic [31:0] rd_p1 = '0, rd_p2 = '0;
   always @(posedge clk) begin
      if (mem_en) begin
         for (int b = 0; b < 4; b++)
            if (mem_we[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
         rd_p1 <= sram[mem_addr];
      end
      rd_p2 <= rd_p1;
   end
   assign mem_rdata = rd_p2;

   typedef struct {
      int          c;
      logic [14:0] a;
      logic [3:0]  we;
      logic [31:0] d;
   } mem_ev_t;
   mem_ev_t mlog[$];

   always @(negedge clk) begin
      mem_ev_t ev;
      if (mem_en) begin
         ev.c = cyc; ev.a = mem_addr; ev.we = mem_we; ev.d = mem_wdata;
         mlog.push_back(ev);
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic send_wr(input logic [16:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int w_lead);
      bit aw_done, w_done, aw_go, w_go;
      int n;
      aw_done = 0; w_done = 0; n = 0;
      awaddr = a; wdata = d; wstrb = s;
      wvalid = 1'b1;
      awvalid = (w_lead == 0);
      while (!(aw_done && w_done) && n < 40) begin
         aw_go = awvalid && awready;
         w_go  = wvalid && wready;
         @(posedge clk); #1; n++;
         if (aw_go) begin awvalid = 1'b0; aw_done = 1; end
         if (w_go)  begin wvalid = 1'b0;  w_done = 1;  end
         if (!aw_done && n >= w_lead) awvalid = 1'b1;
      end
      awvalid = 1'b0; wvalid = 1'b0;
      chk("wr_accept", aw_done && w_done, 1);
   endtask

   task automatic send_rd(input logic [16:0] a);
      bit done, go;
      int n;
      done = 0; n = 0;
      araddr = a; arvalid = 1'b1;
      while (!done && n < 40) begin
         go = arvalid && arready;
         @(posedge clk); #1; n++;
         if (go) begin arvalid = 1'b0; done = 1; end
      end
      arvalid = 1'b0;
      chk("rd_accept", done, 1);
   endtask

   task automatic wait_b(output logic [1:0] resp, output int c);
      bit seen;
      int n;
      seen = 0; n = 0; resp = '0; c = -1;
      bready = 1'b1;
      while (!seen && n < 40) begin
         if (bvalid) begin seen = 1; resp = bresp; c = cyc; end
         @(posedge clk); #1; n++;
      end
      bready = 1'b0;
      chk("b_seen", seen, 1);
   endtask

   task automatic wait_r(output logic [31:0] data, output logic [1:0] resp, output int c);
      bit seen;
      int n;
      seen = 0; n = 0; data = '0; resp = '0; c = -1;
      rready = 1'b1;
      while (!seen && n < 40) begin
         if (rvalid) begin seen = 1; data = rdata; resp = rresp; c = cyc; end
         @(posedge clk); #1; n++;
      end
      rready = 1'b0;
      chk("r_seen", seen, 1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      logic [1:0]  resp;
      logic [31:0] rd;
      int          t0, c, n0, hs_c, n;
      bit          seen, any_rv;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_awready", awready, 0);
      chk("rst_wready",  wready,  0);
      chk("rst_arready", arready, 0);
      chk("rst_bvalid",  bvalid,  0);
      chk("rst_rvalid",  rvalid,  0);
      chk("rst_mem_en",  mem_en,  0);
      chk("rst_rdata",   rdata,   0);
      rst_n = 1'b1;
      #1;
      chk("rel_readies", {awready, wready, arready}, 3'b111);
      @(posedge clk); #1;

      // Full-word write, AW and W together, then readback
      mlog.delete();
      t0 = cyc;
      send_wr(17'h00010, 32'hDEADBEEF, 4'hF, 0);
      wait_b(resp, c);
      chk("w1_bresp", resp, 2'b00);
      chk("w1_b_lat", c - t0, 3);
      chk("w1_nlog", mlog.size(), 1);
      chk("w1_addr", mlog[0].a, 15'd4);
      chk("w1_we",   mlog[0].we, 4'hF);
      chk("w1_data", mlog[0].d, 32'hDEADBEEF);
      chk("w1_m_lat", mlog[0].c - t0, 2);
      t0 = cyc;
      send_rd(17'h00010);
      wait_r(rd, resp, c);
      chk("r1_rdata", rd, 32'hDEADBEEF);
      chk("r1_rresp", resp, 2'b00);
      chk("r1_r_lat", c - t0, 5);
      chk("r1_m_lat", mlog[1].c - t0, 2);
      chk("r1_we",    mlog[1].we, 4'h0);

      // Partial strobe, W leads AW by 3 cycles
      send_wr(17'h00010, 32'h11223344, 4'b0101, 3);
      wait_b(resp, c);
      chk("w2_bresp", resp, 2'b00);
      chk("w2_we", mlog[2].we, 4'b0101);
      send_rd(17'h00013);
      wait_r(rd, resp, c);
      chk("r2_rdata", rd, 32'hDE22BE44);

      // Range boundary: last populated word OK, first unpopulated byte SLVERR
      send_wr(17'h0FFFF, 32'hA5A55A5A, 4'hF, 0);
      wait_b(resp, c);
      chk("wtop_bresp", resp, 2'b00);
      chk("wtop_addr", mlog[mlog.size()-1].a, 15'h3FFF);
      send_rd(17'h0FFFC);
      wait_r(rd, resp, c);
      chk("rtop_rdata", rd, 32'hA5A55A5A);
      n0 = mlog.size();
      send_wr(17'h10000, 32'h12345678, 4'hF, 0);
      wait_b(resp, c);
      chk("woor_bresp", resp, 2'b10);
      send_rd(17'h10000);
      wait_r(rd, resp, c);
      chk("roor_rresp", resp, 2'b10);
      chk("roor_rdata", rd, 32'h0);
      chk("oor_no_mem", mlog.size(), n0);

      // Arbitration: simultaneous write and read after reset -> write first
      do_reset();
      mlog.delete();
      bready = 1'b1; rready = 1'b1;
      fork
         send_wr(17'h00040, 32'h0000_0040, 4'hF, 0);
         send_rd(17'h00010);
      join
      repeat (12) @(posedge clk);
      #1;
      chk("arb1_n",   mlog.size(), 2);
      chk("arb1_1st", mlog[0].we, 4'hF);
      chk("arb1_2nd", mlog[1].we, 4'h0);
      // Last grant was a read, so a second collision again goes to the write
      mlog.delete();
      fork
         send_wr(17'h00044, 32'h0000_0044, 4'hF, 0);
         send_rd(17'h00010);
      join
      repeat (12) @(posedge clk);
      #1;
      chk("arb2_1st", mlog[0].we, 4'hF);
      chk("arb2_2nd", mlog[1].we, 4'h0);
      // Eight back-to-back mixed transactions strictly alternate W,R,W,R...
      mlog.delete();
      fork
         for (int i = 0; i < 4; i++) send_wr(17'h00100 + 17'(4*i), 32'(i), 4'hF, 0);
         for (int i = 0; i < 4; i++) send_rd(17'h00200 + 17'(4*i));
      join
      repeat (30) @(posedge clk);
      #1;
      chk("alt_n", mlog.size(), 8);
      for (int i = 0; i < 8; i++)
         chk($sformatf("alt_%0d", i), mlog[i].we, (i % 2 == 0) ? 4'hF : 4'h0);
      chk("alt_w3_addr", mlog[6].a, 15'h43);
      bready = 1'b0; rready = 1'b0;
      @(posedge clk); #1;

      // B back-pressure: response stable, second write queued behind it
      mlog.delete();
      send_wr(17'h00020, 32'h0000_0001, 4'hF, 0);
      seen = 0; n = 0;
      while (!seen && n < 20) begin
         if (bvalid) seen = 1;
         else begin @(posedge clk); #1; n++; end
      end
      chk("bp_bvalid", seen, 1);
      send_wr(17'h00024, 32'h0000_0002, 4'hF, 0);
      chk("bp_awready", awready, 0);
      chk("bp_wready",  wready,  0);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("bp_hold_v%0d", i), bvalid, 1);
         chk($sformatf("bp_hold_r%0d", i), bresp, 2'b00);
         @(posedge clk); #1;
      end
      chk("bp_no_2nd", mlog.size(), 1);
      hs_c = cyc;
      bready = 1'b1;
      @(posedge clk); #1;
      bready = 1'b0;
      chk("bp_bv_drop", bvalid, 0);
      wait_b(resp, c);
      chk("bp2_bresp", resp, 2'b00);
      chk("bp2_n", mlog.size(), 2);
      chk("bp2_addr", mlog[1].a, 15'd9);
      chk("bp2_after_hs", mlog[1].c > hs_c, 1);

      // Reset while waiting on SRAM read data
      send_rd(17'h00010);
      seen = 0; n = 0;
      while (!seen && n < 10) begin
         if (mem_en) seen = 1;
         else begin @(posedge clk); #1; n++; end
      end
      chk("rw_mem_en", seen, 1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("rw_rvalid0", rvalid, 0);
      chk("rw_mem_en0", mem_en, 0);
      @(posedge clk); #1;
      chk("rw_rvalid1", rvalid, 0);
      rst_n = 1'b1;
      #1;
      chk("rw_readies", {awready, wready, arready}, 3'b111);
      rready = 1'b1;
      any_rv = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         any_rv |= rvalid;
      end
      rready = 1'b0;
      chk("rw_no_stale", any_rv, 0);
      mlog.delete();
      t0 = cyc;
      send_wr(17'h00030, 32'hCAFEF00D, 4'hF, 0);
      wait_b(resp, c);
      chk("rw_w_b_lat", c - t0, 3);
      chk("rw_w_m_lat", mlog[0].c - t0, 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/axil_mem_resp.md
Name: axil_mem_resp

Overview:
- AXI4-Lite responder that terminates one host-facing AXI-Lite slave port (IMEM or DMEM window after the crossbar strips the base address).
- Converts it into single-port synchronous SRAM accesses on a 32-bit word-addressed memory port.
- Instantiated once per memory inside the core. Handles AW/W decoupling, read/write arbitration, byte strobes, out-of-range errors and back-pressure on B/R.

Parameters:
- ADDR_W, 16, byte-address width of s_axil_awaddr/araddr seen by this block (16 for IMEM, 15 for DMEM).
- MEM_BYTES, 65536, populated bytes; addresses >= MEM_BYTES return SLVERR.
- RD_LATENCY, 1, SRAM read latency in cycles (legal values 1 or 2).

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- s_axil_awaddr  in  ADDR_W  write address.
- s_axil_awvalid  in  1  write address valid.
- s_axil_awready  out  1  write address ready.
- s_axil_wdata  in  32  write data.
- s_axil_wstrb  in  4  byte strobes.
- s_axil_wvalid  in  1  write data valid.
- s_axil_wready  out  1  write data ready.
- s_axil_bresp  out  2  write response.
- s_axil_bvalid  out  1  write response valid.
- s_axil_bready  in  1  write response ready.
- s_axil_araddr  in  ADDR_W  read address.
- s_axil_arvalid  in  1  read address valid.
- s_axil_arready  out  1  read address ready.
- s_axil_rdata  out  32  read data.
- s_axil_rresp  out  2  read response.
- s_axil_rvalid  out  1  read data valid.
- s_axil_rready  in  1  read data ready.
- mem_en  out  1  SRAM access enable.
- mem_we  out  4  SRAM byte write enables.
- mem_addr  out  ADDR_W-2  SRAM word address.
- mem_wdata  out  32  SRAM write data.
- mem_rdata  in  32  SRAM read data, valid RD_LATENCY cycles after mem_en with mem_we=0.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All ready/valid outputs 0; bresp, rresp, rdata, mem_* all 0.
  - FSM returns to IDLE and all holding registers are cleared, even mid-transaction; in-flight transactions are dropped.
- AW, W and AR each have a one-entry holding register.
  - awready = !aw_held; wready = !w_held; arready = !ar_held.
  - AW and W are accepted independently, in either order or in the same cycle.
- FSM states: IDLE, WR_MEM, WR_RESP, RD_MEM, RD_WAIT, RD_RESP. Only one transaction is in flight.
- IDLE:
  - If a write (aw_held && w_held) and a read (ar_held) are both pending, grant alternates: after a read grant writes win, after a write grant reads win. The first grant after reset favours the write.
  - Write grant -> WR_MEM. Read grant -> RD_MEM.
- WR_MEM (1 cycle):
  - If address is in range: mem_en=1, mem_we=wstrb, mem_addr=awaddr[ADDR_W-1:2], mem_wdata=wdata.
  - If address is out of range: no memory access.
  - Clears aw_held and w_held; -> WR_RESP with bvalid=1.
  - bresp=OKAY (2'b00), or SLVERR (2'b10) when out of range.
  - wstrb=0 gives OKAY with mem_we=0 (mem_en still pulses).
- WR_RESP:
  - bvalid and bresp are held stable until bready; the cycle bvalid&&bready -> IDLE.
- RD_MEM (1 cycle):
  - mem_en=1 and mem_we=0 if in range; clears ar_held.
  - -> RD_WAIT, whose down-counter is loaded with RD_LATENCY-1.
- RD_WAIT:
  - Runs until the counter reaches 0, then captures mem_rdata into rdata (0 and SLVERR if out of range) and sets rvalid -> RD_RESP.
- RD_RESP:
  - rvalid, rdata and rresp are held until rready -> IDLE.
- Address bits [1:0] are ignored (no unaligned error).
- Range test: addr >= MEM_BYTES, compared at full ADDR_W width.
- Latency with a responsive master (awvalid/wvalid/arvalid seen at cycle T):
  - Write: mem write at T+2 (hold register at T+1, IDLE grant then WR_MEM); bvalid at T+3.
  - Read: mem_en at T+2; rvalid at T+3+RD_LATENCY.
- Holding registers may refill while the FSM is busy, giving at most one queued AW, W and AR.
- mem_* outputs are registered. mem_en is 0 in every state except WR_MEM/RD_MEM.

Decomposition:
- Package pkt_proc_pkg:
  - AXI response codes RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
  - Enum axil_mem_state_t with the six states.
- One natural sub-module: axil_hold_reg, a one-entry valid/ready holding register parameterised by width. It is instantiated three times (AW, W, AR).

Test Plan:
- Write 0x0000_0010 data 0xDEADBEEF strb 4'hF, AW and W same cycle -> mem_we=4'hF at mem_addr 4; bresp=OKAY; read back -> rdata 0xDEADBEEF, rresp OKAY.
- W presented 3 cycles before AW, strb 4'b0101 data 0x11223344 over 0xDEADBEEF -> mem_we=4'b0101; readback 0xDE22BE44.
- Write/read to 0x0001_0000 with MEM_BYTES=65536, ADDR_W=17 -> no mem_en; bresp=2'b10; rresp=2'b10 with rdata 0.
- AR and complete write pending together after reset -> write granted first, then read. Repeat with a read completed last -> write still first; verify alternation over 8 mixed transactions.
- bready held low 5 cycles -> bvalid/bresp stable throughout. A second AW+W is accepted (awready drops after hold); its mem write occurs only after the first B handshake.
- Assert rst_n low while in RD_WAIT with RD_LATENCY=2 -> next cycle rvalid=0, FSM IDLE, all readies 1 after release; no stale rvalid.
